// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, functs,
// datapath select encodings, state codes and the decoded instruction class.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_NOP   = 6'b000000;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_RS   = 2'b11;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    localparam logic [2:0] S_IF     = 3'd0;
    localparam logic [2:0] S_DCD    = 3'd1;
    localparam logic [2:0] S_EXE    = 3'd2;
    localparam logic [2:0] S_MA     = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_BR     = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    typedef struct packed {
        logic rtype_alu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic nop;
        logic bad;
    } insn_class_t;

    function automatic logic [1:0] ext_op_for(input insn_class_t c);
        logic [1:0] e;
        if (c.lui) begin
            e = EXT_LUI;
        end else if (c.lw || c.sw || c.beq) begin
            e = EXT_SIGN;
        end else begin
            e = EXT_ZERO;
        end
        return e;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational op/funct decode into a one-hot instruction class.
module mc_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output insn_class_t cls
);

    // Exactly one class bit is set for any op/funct pair; anything unlisted is bad.
    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU: cls.rtype_alu = 1'b1;
                    FN_JR:            cls.jr        = 1'b1;
                    FN_NOP:           cls.nop       = 1'b1;
                    default:          cls.bad       = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_J:    cls.j   = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: cls.bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM driving datapath enables and selects.
// Optional MC_CTRL_ILLEGAL_HALT_EN: unsupported instructions latch illegal and park in HALT.
module mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [1:0] ExtOp,
    output logic [1:0] ALUOp,
    output logic       ALUSrc,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic [1:0] NPCOp,
    output logic [2:0] state,
    output logic       illegal
);

    insn_class_t cls_s;
    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;

    mc_decode u_decode (
        .op    (op),
        .funct (funct),
        .cls   (cls_s)
    );

    assign state = state_r;

    // Next-state and DM wait-counter sequencing.
    always_comb begin
        state_nxt_s = S_IF;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            S_IF:  state_nxt_s = S_DCD;
            S_DCD: begin
                if (cls_s.rtype_alu || cls_s.ori || cls_s.lui) begin
                    state_nxt_s = S_EXE;
                end else if (cls_s.lw || cls_s.sw) begin
                    state_nxt_s = S_MA;
                end else if (cls_s.beq) begin
                    state_nxt_s = S_BR;
                end else if (cls_s.bad) begin
`ifdef MC_CTRL_ILLEGAL_HALT_EN
                    state_nxt_s = S_HALT;
`else
                    state_nxt_s = S_IF;
`endif
                end else begin
                    state_nxt_s = S_IF;
                end
            end
            S_EXE: state_nxt_s = S_WB;
            S_MA: begin
                state_nxt_s = S_MEM;
                cnt_nxt_s   = 4'(MEM_WAIT);
            end
            S_MEM: begin
                if (cnt_r != 4'd0) begin
                    state_nxt_s = S_MEM;
                    cnt_nxt_s   = cnt_r - 4'd1;
                end else if (cls_s.lw) begin
                    state_nxt_s = S_WB;
                end else begin
                    state_nxt_s = S_IF;
                end
            end
            S_BR:  state_nxt_s = S_IF;
            S_WB:  state_nxt_s = S_IF;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
            S_HALT: state_nxt_s = S_HALT;
`else
            S_HALT: state_nxt_s = S_IF;
`endif
            default: state_nxt_s = S_IF;
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IF;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

`ifdef MC_CTRL_ILLEGAL_HALT_EN
    logic illegal_r;

    // Sticky flag: set on an unsupported instruction in decode, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (state_r == S_DCD && cls_s.bad) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

    // Datapath controls; reset masks everything so no write escapes while rst_n is low.
    always_comb begin
        PCWr   = 1'b0;
        IRWr   = 1'b0;
        RegWr  = 1'b0;
        MemWr  = 1'b0;
        ExtOp  = ext_op_for(cls_s);
        ALUOp  = ALU_ADD;
        ALUSrc = 1'b0;
        RegDst = RD_RT;
        WDSel  = WD_ALU;
        NPCOp  = NPC_PC4;
        if (!rst_n) begin
            ExtOp = EXT_ZERO;
        end else begin
            case (state_r)
                S_IF: begin
                    PCWr = 1'b1;
                    IRWr = 1'b1;
                end
                S_DCD: begin
                    if (cls_s.j) begin
                        PCWr  = 1'b1;
                        NPCOp = NPC_JMP;
                    end else if (cls_s.jal) begin
                        PCWr   = 1'b1;
                        NPCOp  = NPC_JMP;
                        RegWr  = 1'b1;
                        RegDst = RD_RA;
                        WDSel  = WD_PC4;
                    end else if (cls_s.jr) begin
                        PCWr  = 1'b1;
                        NPCOp = NPC_RS;
                    end else begin
                        PCWr = 1'b0;
                    end
                end
                S_EXE: begin
                    if (cls_s.rtype_alu) begin
                        ALUOp = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
                    end else begin
                        // lui relies on the extender's shifted immediate ORed with rs forced to zero
                        ALUOp  = ALU_OR;
                        ALUSrc = 1'b1;
                    end
                end
                S_MA: begin
                    ALUSrc = 1'b1;
                    ExtOp  = EXT_SIGN;
                end
                S_MEM: MemWr = cls_s.sw && (cnt_r == 4'd0);
                S_BR: begin
                    ALUOp = ALU_SUB;
                    if (zero) begin
                        PCWr  = 1'b1;
                        NPCOp = NPC_BR;
                    end else begin
                        PCWr = 1'b0;
                    end
                end
                S_WB: begin
                    RegWr  = 1'b1;
                    RegDst = cls_s.rtype_alu ? RD_RD : RD_RT;
                    WDSel  = cls_s.lw ? WD_DM : WD_ALU;
                end
                default: PCWr = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control vectors are queued per instruction.
`timescale 1ns/1ps
module tb_mc_ctrl;

    localparam int MW = 2;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwr;
        logic       irwr;
        logic       regwr;
        logic       memwr;
        logic [1:0] ext;
        logic [1:0] alu;
        logic       src;
        logic [1:0] dst;
        logic [1:0] wd;
        logic [1:0] npc;
        logic       ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;

    logic       PCWr, IRWr, RegWr, MemWr, ALUSrc, illegal;
    logic [1:0] ExtOp, ALUOp, RegDst, WDSel, NPCOp;
    logic [2:0] state;

    logic       PCWr_w0, IRWr_w0, RegWr_w0, MemWr_w0, ALUSrc_w0, illegal_w0;
    logic [1:0] ExtOp_w0, ALUOp_w0, RegDst_w0, WDSel_w0, NPCOp_w0;
    logic [2:0] state_w0;

    exp_t act;
    assign act = {state, PCWr, IRWr, RegWr, MemWr, ExtOp, ALUOp, ALUSrc,
                  RegDst, WDSel, NPCOp, illegal};

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr), .ExtOp(ExtOp),
        .ALUOp(ALUOp), .ALUSrc(ALUSrc), .RegDst(RegDst), .WDSel(WDSel),
        .NPCOp(NPCOp), .state(state), .illegal(illegal)
    );

    mc_ctrl #(.MEM_WAIT(0)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .PCWr(PCWr_w0), .IRWr(IRWr_w0), .RegWr(RegWr_w0), .MemWr(MemWr_w0),
        .ExtOp(ExtOp_w0), .ALUOp(ALUOp_w0), .ALUSrc(ALUSrc_w0), .RegDst(RegDst_w0),
        .WDSel(WDSel_w0), .NPCOp(NPCOp_w0), .state(state_w0), .illegal(illegal_w0)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t st_only(input logic [2:0] s, input logic [1:0] e);
        exp_t v;
        v     = '0;
        v.st  = s;
        v.ext = e;
        return v;
    endfunction

    task automatic push_bad(input exp_t dcd, input logic [1:0] e);
        exp_t v;
        exp_q.push_back(dcd);
`ifdef MC_CTRL_ILLEGAL_HALT_EN
        for (int k = 0; k < 3; k++) begin
            v     = st_only(3'd7, e);
            v.ill = 1'b1;
            exp_q.push_back(v);
        end
`else
        v = dcd;
`endif
    endtask

    task automatic push_insn(input logic [5:0] o, input logic [5:0] f, input logic z);
        exp_t       v;
        logic [1:0] e;
        if (o == 6'b001111)                                         e = 2'b10;
        else if (o == 6'b100011 || o == 6'b101011 || o == 6'b000100) e = 2'b01;
        else                                                         e = 2'b00;
        v = st_only(3'd0, e); v.pcwr = 1'b1; v.irwr = 1'b1; exp_q.push_back(v);
        v = st_only(3'd1, e);
        case (o)
            6'b001101, 6'b001111: begin
                exp_q.push_back(v);
                v = st_only(3'd2, e); v.alu = 2'b10; v.src = 1'b1; exp_q.push_back(v);
                v = st_only(3'd6, e); v.regwr = 1'b1; exp_q.push_back(v);
            end
            6'b100011, 6'b101011: begin
                exp_q.push_back(v);
                v = st_only(3'd3, 2'b01); v.src = 1'b1; exp_q.push_back(v);
                for (int k = 0; k < MW; k++) exp_q.push_back(st_only(3'd4, e));
                if (o == 6'b100011) begin
                    exp_q.push_back(st_only(3'd4, e));
                    v = st_only(3'd6, e); v.regwr = 1'b1; v.wd = 2'b01; exp_q.push_back(v);
                end else begin
                    v = st_only(3'd4, e); v.memwr = 1'b1; exp_q.push_back(v);
                end
            end
            6'b000100: begin
                exp_q.push_back(v);
                v = st_only(3'd5, e); v.alu = 2'b01; v.pcwr = z;
                v.npc = z ? 2'b01 : 2'b00;
                exp_q.push_back(v);
            end
            6'b000010: begin
                v.pcwr = 1'b1; v.npc = 2'b10; exp_q.push_back(v);
            end
            6'b000011: begin
                v.pcwr = 1'b1; v.regwr = 1'b1; v.dst = 2'b10; v.wd = 2'b10; v.npc = 2'b10;
                exp_q.push_back(v);
            end
            6'b000000: begin
                case (f)
                    6'b100001, 6'b100011: begin
                        exp_q.push_back(v);
                        v = st_only(3'd2, e); v.alu = (f == 6'b100011) ? 2'b01 : 2'b00;
                        exp_q.push_back(v);
                        v = st_only(3'd6, e); v.regwr = 1'b1; v.dst = 2'b01; exp_q.push_back(v);
                    end
                    6'b001000: begin
                        v.pcwr = 1'b1; v.npc = 2'b11; exp_q.push_back(v);
                    end
                    6'b000000: exp_q.push_back(v);
                    default:   push_bad(v, e);
                endcase
            end
            default: push_bad(v, e);
        endcase
    endtask

    // Called just after a falling edge with the DUT in IF.
    task automatic do_insn(input string name, input logic [5:0] o, input logic [5:0] f, input logic z);
        exp_t e;
        int   c;
        op    = o;
        funct = f;
        zero  = z;
        push_insn(o, f, z);
        c = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s c%0d", name, c), {13'd0, act}, {13'd0, e});
            c++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #2;
        check(name, {13'd0, act}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] w0_st [4];
        w0_st[0] = 3'd0; w0_st[1] = 3'd1; w0_st[2] = 3'd3; w0_st[3] = 3'd4;

        op = 6'b001101;
        #3;
        check("reset", {13'd0, act}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_insn("ori",      6'b001101, 6'b000000, 1'b0);
        do_insn("lw",       6'b100011, 6'b000000, 1'b0);
        do_insn("sw",       6'b101011, 6'b000000, 1'b0);
        do_insn("beq_z1",   6'b000100, 6'b000000, 1'b1);
        do_insn("beq_z0",   6'b000100, 6'b000000, 1'b0);
        do_insn("jal",      6'b000011, 6'b000000, 1'b0);
        do_insn("lui",      6'b001111, 6'b000000, 1'b0);
        do_insn("addu",     6'b000000, 6'b100001, 1'b0);
        do_insn("subu",     6'b000000, 6'b100011, 1'b0);
        do_insn("jr",       6'b000000, 6'b001000, 1'b0);
        do_insn("nop",      6'b000000, 6'b000000, 1'b0);
        do_insn("j",        6'b000010, 6'b000000, 1'b0);

        // sw on the zero-wait instance, then reset asserted during its MEM cycle
        do_reset("reset_pre_sw0");
        op    = 6'b101011;
        funct = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("sw0 state c%0d", i), {29'd0, state_w0}, {29'd0, w0_st[i]});
            check($sformatf("sw0 memwr c%0d", i), {31'd0, MemWr_w0}, {31'd0, (i == 3)});
            if (i < 3) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("sw0 abort memwr", {31'd0, MemWr_w0}, 32'd0);
        check("sw0 abort state", {29'd0, state_w0}, 32'd0);
        check("sw abort main",   {13'd0, act}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_insn("bad",      6'b111111, 6'b000000, 1'b0);
        do_reset("reset_post_bad");
        do_insn("ori_post", 6'b001101, 6'b000000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
